// File: rtl/hazard_fwd_unit_pkg.sv
// hfu_pkg: shared types and constants for the hazard/forwarding unit.
package hfu_pkg;
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } hfu_state_t;

    // Width of the load-stall bubble counter; covers LOAD_LAT up to 15.
    localparam int HFU_LCNT_W = 4;

    function automatic int sel_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/hfu_fwd_sel.sv
// hfu_fwd_sel: per-source forwarding priority encoder, youngest matching stage wins.
// Optional HFU_ZERO_REG_EN makes register 0 never match.
module hfu_fwd_sel
    import hfu_pkg::*;
#(
    parameter int REG_ADDR_W     = 4,
    parameter int NUM_FWD_STAGES = 2,
    parameter int SEL_W          = 2
)(
    input  logic [REG_ADDR_W-1:0]                i_src_addr,
    input  logic                                 i_src_valid,
    input  logic [NUM_FWD_STAGES-1:0]            i_stage_wr,
    input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] i_stage_rd,
    output logic [SEL_W-1:0]                     o_sel
);
    logic w_zero_ok;

`ifdef HFU_ZERO_REG_EN
    assign w_zero_ok = |i_src_addr;
`else
    assign w_zero_ok = 1'b1;
`endif

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        o_sel = '0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--)
            if (i_src_valid && w_zero_ok && i_stage_wr[k] &&
                i_stage_rd[k*REG_ADDR_W +: REG_ADDR_W] == i_src_addr)
                o_sel = SEL_W'(NUM_FWD_STAGES - k);
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding select, load-use stall/bubble FSM and stall counter.
// Optional macro HFU_ZERO_REG_EN: register address 0 never forwards or stalls.
module hazard_fwd_unit
    import hfu_pkg::*;
#(
    parameter int REG_ADDR_W     = 4,
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int CNT_W          = 16,
    localparam int SEL_W         = sel_w(NUM_FWD_STAGES)
)(
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]        id_ex_src_addr,
    input  logic [NUM_SRC-1:0]                   id_ex_src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]        if_id_src_addr,
    input  logic [NUM_SRC-1:0]                   if_id_src_valid,
    input  logic [REG_ADDR_W-1:0]                id_ex_rd,
    input  logic                                 id_ex_regWrite,
    input  logic                                 id_ex_memRead,
    input  logic [NUM_FWD_STAGES-1:0]            stage_regWrite,
    input  logic [NUM_FWD_STAGES*REG_ADDR_W-1:0] stage_rd,
    input  logic                                 mem_busy,
    input  logic                                 stat_clear,
    output logic [NUM_SRC*SEL_W-1:0]             forward_sel,
    output logic                                 stall,
    output logic                                 bubble,
    output logic [CNT_W-1:0]                     stall_count
);
    hfu_state_t              r_state;
    hfu_state_t              w_nstate;
    logic [HFU_LCNT_W-1:0]   r_cnt;
    logic [HFU_LCNT_W-1:0]   w_ncnt;
    logic [CNT_W-1:0]        r_stall_count;
    logic [NUM_SRC*SEL_W-1:0] w_fsel;
    logic                    w_hazard;
    logic                    w_stall;
    logic                    w_bubble;
    logic                    w_zero_ok;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hfu_fwd_sel #(
            .REG_ADDR_W    (REG_ADDR_W),
            .NUM_FWD_STAGES(NUM_FWD_STAGES),
            .SEL_W         (SEL_W)
        ) u_sel (
            .i_src_addr (id_ex_src_addr[s*REG_ADDR_W +: REG_ADDR_W]),
            .i_src_valid(id_ex_src_valid[s]),
            .i_stage_wr (stage_regWrite),
            .i_stage_rd (stage_rd),
            .o_sel      (w_fsel[s*SEL_W +: SEL_W])
        );
    end

`ifdef HFU_ZERO_REG_EN
    assign w_zero_ok = |id_ex_rd;
`else
    assign w_zero_ok = 1'b1;
`endif

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (if_id_src_valid[i] && if_id_src_addr[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd)
                w_hazard = 1'b1;
        w_hazard = w_hazard && id_ex_memRead && id_ex_regWrite && w_zero_ok;
    end

    // mem_busy overrides everything: freeze the front end without injecting bubbles.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        if (mem_busy) begin
            w_stall  = 1'b1;
            w_nstate = MEM_WAIT;
        end else begin
            case (r_state)
                RUN: if (w_hazard) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_ncnt   = HFU_LCNT_W'(LOAD_LAT - 1);
                        w_nstate = LOAD_STALL;
                    end
                end
                LOAD_STALL: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    w_ncnt   = r_cnt - 1'b1;
                    w_nstate = (r_cnt <= 1) ? RUN : LOAD_STALL;
                end
                default: begin
                    w_ncnt   = '0;
                    w_nstate = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            if (stat_clear)
                r_stall_count <= '0;
            else if (w_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign stall       = reset_n & w_stall;
    assign bubble      = reset_n & w_bubble;
    assign forward_sel = reset_n ? w_fsel : '0;
    assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks of forwarding, load-use stalls, mem_busy, reset and counters.
module tb_hazard_fwd_unit;
    logic        clock;
    logic        reset_n;
    logic [7:0]  id_ex_src_addr;
    logic [1:0]  id_ex_src_valid;
    logic [7:0]  if_id_src_addr;
    logic [1:0]  if_id_src_valid;
    logic [3:0]  id_ex_rd;
    logic        id_ex_regWrite;
    logic        id_ex_memRead;
    logic [1:0]  stage_regWrite;
    logic [7:0]  stage_rd;
    logic        mem_busy;
    logic        stat_clear;
    logic [3:0]  forward_sel;
    logic        stall;
    logic        bubble;
    logic [15:0] stall_count;
    logic [3:0]  fs_s;
    logic        stall_s;
    logic        bubble_s;
    logic [3:0]  sc_s;
    int errors = 0;
    int checks = 0;

    hazard_fwd_unit #(.LOAD_LAT(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_ex_src_addr(id_ex_src_addr), .id_ex_src_valid(id_ex_src_valid),
        .if_id_src_addr(if_id_src_addr), .if_id_src_valid(if_id_src_valid),
        .id_ex_rd(id_ex_rd), .id_ex_regWrite(id_ex_regWrite), .id_ex_memRead(id_ex_memRead),
        .stage_regWrite(stage_regWrite), .stage_rd(stage_rd),
        .mem_busy(mem_busy), .stat_clear(stat_clear),
        .forward_sel(forward_sel), .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    hazard_fwd_unit #(.CNT_W(4)) dut_s (
        .clock(clock), .reset_n(reset_n),
        .id_ex_src_addr(id_ex_src_addr), .id_ex_src_valid(id_ex_src_valid),
        .if_id_src_addr(if_id_src_addr), .if_id_src_valid(if_id_src_valid),
        .id_ex_rd(id_ex_rd), .id_ex_regWrite(id_ex_regWrite), .id_ex_memRead(id_ex_memRead),
        .stage_regWrite(stage_regWrite), .stage_rd(stage_rd),
        .mem_busy(mem_busy), .stat_clear(stat_clear),
        .forward_sel(fs_s), .stall(stall_s), .bubble(bubble_s), .stall_count(sc_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_ex_src_addr  = '0;
        id_ex_src_valid = '0;
        if_id_src_addr  = '0;
        if_id_src_valid = '0;
        id_ex_rd        = '0;
        id_ex_regWrite  = 1'b0;
        id_ex_memRead   = 1'b0;
        stage_regWrite  = '0;
        stage_rd        = '0;
        mem_busy        = 1'b0;
        stat_clear      = 1'b0;
    endtask

    task automatic load_use_r4();
        id_ex_memRead   = 1'b1;
        id_ex_regWrite  = 1'b1;
        id_ex_rd        = 4'd4;
        if_id_src_addr  = 8'h04;
        if_id_src_valid = 2'b01;
    endtask

    task automatic stat_clear_cycle();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        load_use_r4();
        stage_regWrite = 2'b11; stage_rd = 8'h33;
        id_ex_src_addr = 8'h33; id_ex_src_valid = 2'b11;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b expected 0", bubble); end
        checks++; if (forward_sel !== 4'h0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", forward_sel); end
        checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", stall_count); end
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        stage_rd = 8'h33; stage_regWrite = 2'b11;
        id_ex_src_addr = 8'h03; id_ex_src_valid = 2'b01;
        #1;
        checks++; if (forward_sel[1:0] !== 2'b10) begin errors++; $display("FAIL fwd_youngest: got %b expected 10", forward_sel[1:0]); end
        stage_rd = 8'h53; id_ex_src_addr = 8'h53; id_ex_src_valid = 2'b01;
        #1;
        checks++; if (forward_sel !== 4'b0010) begin errors++; $display("FAIL fwd_invalid_src: got %b expected 0010", forward_sel); end
        id_ex_src_valid = 2'b11;
        #1;
        checks++; if (forward_sel !== 4'b0110) begin errors++; $display("FAIL fwd_memwb: got %b expected 0110", forward_sel); end
        stage_rd = 8'h33; stage_regWrite = 2'b10; id_ex_src_addr = 8'h33;
        #1;
        checks++; if (forward_sel !== 4'b0101) begin errors++; $display("FAIL fwd_stage1_only: got %b expected 0101", forward_sel); end
        id_ex_src_addr = 8'h77;
        #1;
        checks++; if (forward_sel !== 4'b0000) begin errors++; $display("FAIL fwd_none: got %b expected 0000", forward_sel); end
        clear_inputs();
    endtask

    task automatic test_load_use();
        stat_clear_cycle();
        load_use_r4();
        if_id_src_valid = 2'b10;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_invalid_src: got %b expected 0", stall); end
        if_id_src_valid = 2'b01;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL lu_cycle%0d: got %b expected 11", c, {stall, bubble}); end
            tick();
            id_ex_memRead = 1'b0;
            #1;
        end
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL lu_done: got %b expected 00", {stall, bubble}); end
        checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL lu_count: got %0d expected 3", stall_count); end
        clear_inputs();
    endtask

    task automatic test_mem_busy();
        load_use_r4();
        #1;
        checks++; if ({stall, bubble} !== 2'b11) begin errors++; $display("FAIL mb_start: got %b expected 11", {stall, bubble}); end
        tick();
        id_ex_memRead = 1'b0;
        mem_busy = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            checks++; if ({stall, bubble} !== 2'b10) begin errors++; $display("FAIL mb_busy%0d: got %b expected 10", c, {stall, bubble}); end
            tick();
        end
        mem_busy = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL mb_after%0d: got %b expected 00", c, {stall, bubble}); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        load_use_r4();
        tick();
        id_ex_memRead = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rm_in_stall: got %b expected 1", stall); end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL rm_async: got %b expected 00", {stall, bubble}); end
        checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", stall_count); end
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rm_release: got %b expected 0", stall); end
        tick();
        checks++; if ({stall, bubble} !== 2'b00) begin errors++; $display("FAIL rm_run: got %b expected 00", {stall, bubble}); end
        clear_inputs();
    endtask

    task automatic test_saturate();
        stat_clear_cycle();
        mem_busy = 1'b1;
        repeat (20) tick();
        checks++; if (sc_s !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", sc_s); end
        checks++; if (stall_count !== 16'd20) begin errors++; $display("FAIL sat_cnt16: got %0d expected 20", stall_count); end
        stat_clear = 1'b1;
        tick();
        checks++; if (sc_s !== 4'd0) begin errors++; $display("FAIL sat_clear_wins: got %0d expected 0", sc_s); end
        clear_inputs();
        tick();
    endtask

    task automatic test_zero_reg();
        id_ex_memRead = 1'b1; id_ex_regWrite = 1'b1; id_ex_rd = 4'd0;
        if_id_src_addr = 8'h00; if_id_src_valid = 2'b01;
        stage_regWrite = 2'b01; stage_rd = 8'h00;
        id_ex_src_addr = 8'h00; id_ex_src_valid = 2'b01;
        #1;
`ifdef HFU_ZERO_REG_EN
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL zr_stall: got %b expected 0", stall_s); end
        checks++; if (forward_sel !== 4'b0000) begin errors++; $display("FAIL zr_fwd: got %b expected 0000", forward_sel); end
`else
        checks++; if ({stall_s, bubble_s} !== 2'b11) begin errors++; $display("FAIL zr_stall: got %b expected 11", {stall_s, bubble_s}); end
        checks++; if (forward_sel !== 4'b0010) begin errors++; $display("FAIL zr_fwd: got %b expected 0010", forward_sel); end
`endif
        tick();
        id_ex_memRead = 1'b0;
        #1;
        checks++; if (stall_s !== 1'b0) begin errors++; $display("FAIL zr_one_cycle: got %b expected 0", stall_s); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_busy();
        test_reset_mid_stall();
        test_saturate();
        test_zero_reg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
